instr_fetch: RTL

//  Fetch sequencer directly downstream of program_counter. Reads the PC onto

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 96 +++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: PC read/increment, memory read port and decoder handoff.
`timescale 1ns/100ps
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] pcBus;
    logic                  pcNotRead;
    logic                  pcInc;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memReq;
    logic                  memAck;
    logic [DATA_WIDTH-1:0] memData;
    logic [DATA_WIDTH-1:0] ir;
    logic                  irValid;
    logic                  irTaken;
    logic                  fetchErr;

    modport master (
        input  pcBus, memAck, memData, irTaken,
        output pcNotRead, pcInc, memAddr, memReq, ir, irValid, fetchErr
    );

    modport slave (
        output pcBus, memAck, memData, irTaken,
        input  pcNotRead, pcInc, memAddr, memReq, ir, irValid, fetchErr
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch sequencer: reads PC, issues one memory read per instruction, latches it
// into ir, pulses the PC increment and holds the word until the decoder takes it.
`timescale 1ns/100ps
module instr_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 notClr,
    input  logic                 enable,
    input  logic                 flush,
    instr_fetch_if.master        bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX_WAIT  = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ADDR, REQ, INC, HOLD, ERR} state_t;

    state_t                state_reg,    state_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] ir_reg,       ir_next;
    logic [CW-1:0]         wait_cnt_reg, wait_cnt_next;
    state_t                resume_state;

    always_ff @(posedge clk or negedge notClr) begin
        if (!notClr) begin
            state_reg    <= IDLE;
            mem_addr_reg <= '0;
            ir_reg       <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mem_addr_reg <= mem_addr_next;
            ir_reg       <= ir_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Where a flush or a taken instruction sends the sequencer.
    assign resume_state = enable ? ADDR : IDLE;

    always_comb begin
        state_next    = state_reg;
        mem_addr_next = mem_addr_reg;
        ir_next       = ir_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = ADDR;
            end
            ADDR: begin
                if (flush) begin
                    state_next = resume_state;
                end else begin
                    mem_addr_next = bus.pcBus;
                    wait_cnt_next = '0;
                    state_next    = REQ;
                end
            end
            REQ: begin
                // flush beats the ack; ack on the final allowed edge beats timeout.
                if (flush) begin
                    state_next = resume_state;
                end else if (bus.memAck) begin
                    ir_next    = bus.memData;
                    state_next = INC;
                end else begin
                    if (wait_cnt_reg < MAX_WAIT) wait_cnt_next = wait_cnt_reg + 1'b1;
                    if (wait_cnt_reg >= LAST_WAIT) state_next = ERR;
                end
            end
            INC: begin
                state_next = flush ? resume_state : HOLD;
            end
            HOLD: begin
                if (flush || bus.irTaken) state_next = resume_state;
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.pcNotRead = (state_reg != ADDR);
    assign bus.pcInc     = (state_reg == INC) & ~flush;
    assign bus.memAddr   = mem_addr_reg;
    assign bus.memReq    = (state_reg == REQ);
    assign bus.ir        = ir_reg;
    assign bus.irValid   = (state_reg == HOLD);
    assign bus.fetchErr  = (state_reg == ERR);
endmodule
